// File: rtl/vr_arb_pkg.sv
// Shared definitions for the round-robin valid/ready arbiter:
// legal requester-count range, lock-state encoding and the source-index
// width helper used by the interface, the grant unit and the top.
package vr_arb_pkg;

  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 8;

  // Grant unit state: free-running round robin, or pinned to one requester
  // until its burst ends.
  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Bits needed to encode a requester index; never less than one.
  function automatic int src_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/vr_rr_arbiter_if.sv
// Bundle of all stream signals around the arbiter: NUM_IN upstream
// valid/ready/data/last lanes plus the single downstream stream with its
// source index. Names are from the arbiter's point of view.
interface vr_rr_arbiter_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4
);
  import vr_arb_pkg::*;

  localparam int SRC_W = src_w(NUM_IN);

  // Upstream requesters
  logic [NUM_IN-1:0]       i_valid;
  logic [NUM_IN*WIDTH-1:0] i_data;
  logic [NUM_IN-1:0]       i_last;
  logic [NUM_IN-1:0]       o_ready;

  // Downstream stream
  logic                    o_valid;
  logic [WIDTH-1:0]        o_data;
  logic                    o_last;
  logic [SRC_W-1:0]        o_src;
  logic                    i_ready;

  // Arbiter side
  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_data, o_last, o_src
  );

  // Environment side (requesters and downstream sink)
  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_src
  );

endinterface

// File: rtl/vr_rr_grant.sv
// Round-robin grant unit: rotating priority pointer, optional burst lock
// and the combinational grant search.
// Build option: define VR_RR_ARBITER_BURST_LOCK_EN to keep the grant on a
// requester until it transfers a beat with last set.
module vr_rr_grant
  import vr_arb_pkg::*;
#(
  parameter  int NUM_IN = 4,
  localparam int SRC_W  = src_w(NUM_IN)
) (
  input  logic              i_clk,
  input  logic              i_srst_n,
  input  logic [NUM_IN-1:0] i_valid,
`ifdef VR_RR_ARBITER_BURST_LOCK_EN
  input  logic [NUM_IN-1:0] i_last,
`endif
  input  logic              i_load_en,
  output logic [SRC_W-1:0]  o_grant,
  output logic              o_grant_vld
);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [SRC_W-1:0] r_ptr;
  logic [SRC_W-1:0] w_ptr_nxt;
  logic [SRC_W-1:0] w_grant;
  logic [SRC_W-1:0] w_grant_inc;
  logic             w_grant_vld;
  logic             w_xfer;
  logic [SRC_W:0]   w_idx;

  // Grant search: first valid requester from r_ptr upward with wrap; a
  // locked burst pins the grant to r_ptr.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    w_grant     = r_ptr;
    w_grant_vld = 1'b0;
    w_idx       = '0;
    if (r_state == ARB_LOCKED) begin
      w_grant_vld = i_valid[r_ptr];
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        w_idx = {1'b0, r_ptr} + (SRC_W+1)'(i);
        if (w_idx >= (SRC_W+1)'(NUM_IN)) begin
          w_idx = w_idx - (SRC_W+1)'(NUM_IN);
        end
        if (!w_grant_vld && i_valid[w_idx[SRC_W-1:0]]) begin
          w_grant     = w_idx[SRC_W-1:0];
          w_grant_vld = 1'b1;
        end
      end
    end
  end

  assign w_xfer      = i_load_en & w_grant_vld;
  assign w_grant_inc = (w_grant == SRC_W'(NUM_IN - 1)) ? '0 : w_grant + 1'b1;

  // Next pointer / lock state: advance past the winner once its beat (or
  // burst) is accepted; otherwise hold.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    if (w_xfer) begin
`ifdef VR_RR_ARBITER_BURST_LOCK_EN
      if (!i_last[w_grant]) begin
        w_state_nxt = ARB_LOCKED;
        w_ptr_nxt   = w_grant;
      end else begin
        w_state_nxt = ARB_FREE;
        w_ptr_nxt   = w_grant_inc;
      end
`else
      w_state_nxt = ARB_FREE;
      w_ptr_nxt   = w_grant_inc;
`endif
    end
  end

  // Pointer and lock state register, synchronous clear to requester 0.
  always_ff @(posedge i_clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (!i_srst_n) begin
      r_state <= ARB_FREE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_vld = w_grant_vld;

endmodule

// File: rtl/vr_rr_arbiter.sv
// NUM_IN-to-1 round-robin valid/ready arbiter with a one-entry registered
// output stage. Grant selection lives in vr_rr_grant; this level owns the
// load enable, per-requester ready, payload mux and output register.
// Build option: VR_RR_ARBITER_BURST_LOCK_EN enables burst locking; when
// undefined, arbitration happens every beat and i_last only passes through.
module vr_rr_arbiter
  import vr_arb_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4
) (
  input  logic           i_clk,
  input  logic           i_srst_n,
  vr_rr_arbiter_if.slave io_bus
);

  localparam int SRC_W = src_w(NUM_IN);

  if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
    $error("vr_rr_arbiter: NUM_IN outside legal range");
  end

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_last;
  logic [SRC_W-1:0] r_src;

  logic             w_load_en;
  logic [SRC_W-1:0] w_grant;
  logic             w_grant_vld;

  // Stage accepts a new beat when empty or being drained; forced low in
  // reset so no requester sees ready then.
  assign w_load_en = i_srst_n & (~r_valid | io_bus.i_ready);

  vr_rr_grant #(
    .NUM_IN (NUM_IN)
  ) u_grant (
    .i_clk       (i_clk),
    .i_srst_n    (i_srst_n),
    .i_valid     (io_bus.i_valid),
`ifdef VR_RR_ARBITER_BURST_LOCK_EN
    .i_last      (io_bus.i_last),
`endif
    .i_load_en   (w_load_en),
    .o_grant     (w_grant),
    .o_grant_vld (w_grant_vld)
  );

  // One-hot ready to the granted requester only.
  always_comb begin
    io_bus.o_ready = '0;
    if (w_load_en && w_grant_vld) begin
      io_bus.o_ready[w_grant] = 1'b1;
    end
  end

  // Output register stage: load the granted beat, empty when nothing is
  // granted, hold while downstream stalls.
  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_src   <= '0;
    end else if (w_load_en) begin
      r_valid <= w_grant_vld;
      if (w_grant_vld) begin
        r_data <= io_bus.i_data[int'(w_grant)*WIDTH +: WIDTH];
        r_last <= io_bus.i_last[w_grant];
        r_src  <= w_grant;
      end
    end
  end

  assign io_bus.o_valid = r_valid;
  assign io_bus.o_data  = r_data;
  assign io_bus.o_last  = r_last;
  assign io_bus.o_src   = r_src;

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Directed and randomized checks for vr_rr_arbiter (NUM_IN=4, WIDTH=16).
// Expectations for burst-related steps depend on VR_RR_ARBITER_BURST_LOCK_EN.
module tb_vr_rr_arbiter;
  import vr_arb_pkg::*;

  localparam int WIDTH  = 16;
  localparam int NUM_IN = 4;
  localparam int RAND_CYCLES = 10000;

  logic i_clk = 1'b0;
  logic i_srst_n;

  vr_rr_arbiter_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) bus ();

  vr_rr_arbiter #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .i_clk    (i_clk),
    .i_srst_n (i_srst_n),
    .io_bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge i_clk);
    #2;
  endtask

  task automatic set_data(input int k, input logic [WIDTH-1:0] d);
    bus.i_data[k*WIDTH +: WIDTH] = d;
  endtask

  task automatic drive_req1(input int beat);
    bus.i_valid[1] = (beat <= 3);
    set_data(1, 16'hB000 + 16'(beat));
    bus.i_last[1]  = (beat == 3);
  endtask

  // Burst step expectations (requester 1: 3 beats, requester 0 always valid)
`ifdef VR_RR_ARBITER_BURST_LOCK_EN
  logic [1:0]  exp_src  [6] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
  logic [15:0] exp_dat  [6] = '{16'hB001, 16'hB002, 16'hB003, 16'h0C00, 16'h0C00, 16'h0C00};
  logic        exp_lst  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`else
  logic [1:0]  exp_src  [6] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
  logic [15:0] exp_dat  [6] = '{16'hB001, 16'h0C00, 16'hB002, 16'h0C00, 16'hB003, 16'h0C00};
  logic        exp_lst  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`endif

  // Random-phase scoreboard
  logic [WIDTH:0] exp_q [NUM_IN][$];
  int             seq [NUM_IN];
  int             n_in, n_out, n_onehot_bad, n_grant_bad;

  initial begin
    int             beat;
    logic           x1;
    logic           acc [NUM_IN];
    logic           out_fire;
    logic [1:0]     out_src;
    logic [WIDTH:0] out_beat;
    logic [WIDTH:0] exp_beat;

    // ---------------- Reset state ----------------
    i_srst_n    = 1'b0;
    bus.i_valid = '1;
    bus.i_last  = '1;
    bus.i_data  = '0;
    bus.i_ready = 1'b1;
    cyc();
    cyc();
    #1;
    check("rst_ready", 32'(bus.o_ready), 32'h0);
    check("rst_valid", 32'(bus.o_valid), 32'h0);
    check("rst_src",   32'(bus.o_src),   32'h0);
    check("rst_data",  32'(bus.o_data),  32'h0);
    check("rst_last",  32'(bus.o_last),  32'h0);

    // ---------------- Fair rotation, all valid ----------------
    i_srst_n = 1'b1;
    for (int k = 0; k < NUM_IN; k++) set_data(k, 16'h1000 + 16'(k));
    #1;
    check("rot_ready0", 32'(bus.o_ready), 32'h1);
    check("rot_valid0", 32'(bus.o_valid), 32'h0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      #1;
      check($sformatf("rot_src%0d", i),   32'(bus.o_src),   32'(i % 4));
      check($sformatf("rot_data%0d", i),  32'(bus.o_data),  32'h1000 + 32'(i % 4));
      check($sformatf("rot_ready%0d", i), 32'(bus.o_ready), 32'(1 << ((i + 1) % 4)));
    end
    bus.i_valid = '0;
    cyc();
    #1;
    check("idle_clear", 32'(bus.o_valid), 32'h0);

    // ---------------- Backpressure hold ----------------
    bus.i_valid = 4'b0100;
    set_data(2, 16'hA5A5);
    bus.i_ready = 1'b0;
    #1;
    check("bp_ready_empty", 32'(bus.o_ready), 32'h4);
    cyc();
    #1;
    set_data(2, 16'h5A5A);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_valid%0d", i), 32'(bus.o_valid), 32'h1);
      check($sformatf("bp_data%0d", i),  32'(bus.o_data),  32'hA5A5);
      check($sformatf("bp_src%0d", i),   32'(bus.o_src),   32'h2);
      check($sformatf("bp_ready%0d", i), 32'(bus.o_ready), 32'h0);
      cyc();
      #1;
    end
    check("bp_hold_end", 32'(bus.o_data), 32'hA5A5);
    bus.i_ready = 1'b1;
    #1;
    check("bp_ready_release", 32'(bus.o_ready), 32'h4);
    cyc();
    #1;
    check("bp_next_data", 32'(bus.o_data), 32'h5A5A);
    check("bp_next_src",  32'(bus.o_src),  32'h2);
    bus.i_valid = '0;
    cyc();
    #1;
    check("bp_drain", 32'(bus.o_valid), 32'h0);

    // ---------------- Burst from requester 1 vs requester 0 ----------------
    bus.i_valid = 4'b0001;
    set_data(0, 16'h0C00);
    bus.i_last  = 4'b0001;
    cyc();
    #1;
    check("burst_pre_src", 32'(bus.o_src), 32'h0);
    beat = 1;
    drive_req1(beat);
    for (int i = 0; i < 6; i++) begin
      #1;
      x1 = bus.o_ready[1];
      cyc();
      if (x1) beat++;
      #1;
      check($sformatf("burst_src%0d", i),  32'(bus.o_src),  32'(exp_src[i]));
      check($sformatf("burst_data%0d", i), 32'(bus.o_data), 32'(exp_dat[i]));
      check($sformatf("burst_last%0d", i), 32'(bus.o_last), 32'(exp_lst[i]));
      drive_req1(beat);
    end
    bus.i_valid = '0;
    cyc();

    // ---------------- Reset with a held beat ----------------
    bus.i_valid = 4'b0001;
    set_data(0, 16'h7777);
    bus.i_last  = '1;
    bus.i_ready = 1'b0;
    cyc();
    #1;
    check("mrst_held_valid", 32'(bus.o_valid), 32'h1);
    i_srst_n    = 1'b0;
    bus.i_valid = 4'b0101;
    set_data(0, 16'h0AAA);
    set_data(2, 16'h2222);
    #1;
    check("mrst_ready", 32'(bus.o_ready), 32'h0);
    cyc();
    #1;
    check("mrst_valid", 32'(bus.o_valid), 32'h0);
    check("mrst_data",  32'(bus.o_data),  32'h0);
    i_srst_n    = 1'b1;
    bus.i_ready = 1'b1;
    #1;
    check("mrst_first_ready", 32'(bus.o_ready), 32'h1);
    cyc();
    #1;
    check("mrst_first_src",  32'(bus.o_src),  32'h0);
    check("mrst_first_data", 32'(bus.o_data), 32'h0AAA);
    bus.i_valid = '0;
    cyc();
    cyc();

    // ---------------- Random traffic with scoreboard ----------------
    n_in = 0; n_out = 0; n_onehot_bad = 0; n_grant_bad = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      seq[k] = 0;
      set_data(k, {4'(k), 12'(seq[k])});
      bus.i_last[k] = ($urandom_range(0, 2) == 0);
    end
    bus.i_valid = '0;
    for (int c = 0; c < RAND_CYCLES + 16; c++) begin
      #1;
      if ($countones(bus.o_ready) > 1) n_onehot_bad++;
      if ((bus.o_ready & ~bus.i_valid) != '0) n_grant_bad++;
      out_fire = bus.o_valid & bus.i_ready;
      out_src  = bus.o_src;
      out_beat = {bus.o_last, bus.o_data};
      for (int k = 0; k < NUM_IN; k++) begin
        acc[k] = bus.o_ready[k] & bus.i_valid[k];
      end
      if (out_fire) begin
        n_out++;
        check("rand_q_nonempty", 32'(exp_q[out_src].size() != 0), 32'h1);
        if (exp_q[out_src].size() != 0) begin
          exp_beat = exp_q[out_src].pop_front();
          check($sformatf("rand_beat_src%0d", out_src), 32'(out_beat), 32'(exp_beat));
        end
      end
      for (int k = 0; k < NUM_IN; k++) begin
        if (acc[k]) begin
          exp_q[k].push_back({bus.i_last[k], bus.i_data[k*WIDTH +: WIDTH]});
          n_in++;
        end
      end
      cyc();
      for (int k = 0; k < NUM_IN; k++) begin
        if (acc[k]) begin
          seq[k]++;
          set_data(k, {4'(k), 12'(seq[k])});
          bus.i_last[k]  = ($urandom_range(0, 2) == 0);
          bus.i_valid[k] = (c < RAND_CYCLES) && ($urandom_range(0, 9) < 6);
        end else if (!bus.i_valid[k]) begin
          bus.i_valid[k] = (c < RAND_CYCLES) && ($urandom_range(0, 9) < 5);
        end
      end
      bus.i_ready = (c >= RAND_CYCLES) || ($urandom_range(0, 9) < 7);
    end
    check("rand_onehot_viol", 32'(n_onehot_bad), 32'h0);
    check("rand_grant_viol",  32'(n_grant_bad),  32'h0);
    check("rand_in_eq_out",   32'(n_out),        32'(n_in));
    for (int k = 0; k < NUM_IN; k++) begin
      check($sformatf("rand_q_empty%0d", k), 32'(exp_q[k].size()), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
